// File: rtl/nes_pkg.sv
// Shared NES CPU-bus constants and the sprite DMA state encoding.
// Imported by the DMA initiator and its bench.
package nes_pkg;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/spr_dma_ctrl_if.sv
// Snooped CPU bus plus the sprite-port request/grant bus between DMA and arbiter.
// master = DMA initiator side, slave = arbiter / shared-bus side.
interface spr_dma_ctrl_if;

  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic        dma_busy;

  modport master (
    input  bus_addr, bus_wn, bus_wdata, spr_gnt, spr_rdata,
    output spr_req, spr_addr, spr_wn, spr_wdata, dma_busy
  );

  modport slave (
    output bus_addr, bus_wn, bus_wdata, spr_gnt, spr_rdata,
    input  spr_req, spr_addr, spr_wn, spr_wdata, dma_busy
  );

endinterface

// File: rtl/spr_dma_ctrl.sv
// Sprite OAM DMA: snoops $4014 writes, then copies page $XX00-$XXFF to $2004 as read/write pairs.
// All outputs are registered; a non-granted cycle freezes state, index, data and outputs.
module spr_dma_ctrl #(
  parameter logic [15:0] OAMDMA_ADDR  = nes_pkg::OAMDMA_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = nes_pkg::OAMDATA_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_spr_req,
  input  logic        i_spr_gnt,
  output logic [15:0] o_spr_addr,
  output logic        o_spr_wn,
  output logic [7:0]  o_spr_wdata,
  input  logic [7:0]  i_spr_rdata,
  output logic        o_dma_busy
);
  import nes_pkg::*;

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  align_q, align_d;
  logic        parity_q, parity_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic [15:0] addr_q, addr_d;
  logic        wn_q, wn_d;
  logic [7:0]  wdata_q, wdata_d;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    align_d  = align_q;
    parity_d = ~parity_q;

    case (state_q)
      IDLE: begin
        if (!i_bus_wn && (i_bus_addr == OAMDMA_ADDR)) begin
          page_d  = i_bus_wdata;
          idx_d   = 8'h00;
          // an odd-cycle trigger costs one extra dummy read to realign
          align_d = parity_q ? 2'd2 : 2'd1;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (i_spr_gnt) begin
          align_d = align_q - 2'd1;
          if (align_q == 2'd1) state_d = READ;
        end
      end
      READ: begin
        if (i_spr_gnt) begin
          data_d  = i_spr_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (i_spr_gnt) begin
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == 8'hFF) ? IDLE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so they appear as flops aligned with state_q.
  always_comb begin
    req_d   = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    addr_d  = 16'h0000;
    wn_d    = 1'b1;
    wdata_d = 8'h00;
    case (state_d)
      ALIGN:   addr_d = OAMDATA_ADDR;
      READ:    addr_d = {page_d, idx_d};
      WRITE: begin
        addr_d  = OAMDATA_ADDR;
        wn_d    = 1'b0;
        wdata_d = data_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      align_q  <= 2'd0;
      parity_q <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= 16'h0000;
      wn_q     <= 1'b1;
      wdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      align_q  <= align_d;
      parity_q <= parity_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wn_q     <= wn_d;
      wdata_q  <= wdata_d;
    end
  end

  assign o_spr_req   = req_q;
  assign o_dma_busy  = busy_q;
  assign o_spr_addr  = addr_q;
  assign o_spr_wn    = wn_q;
  assign o_spr_wdata = wdata_q;

endmodule

// File: tb/tb_spr_dma_ctrl.sv
// Directed bench for spr_dma_ctrl: memory returns addr[7:0]^5A, a negedge monitor tallies traffic.
module tb_spr_dma_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spr_dma_ctrl_if bus_if();

  spr_dma_ctrl dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_bus_addr  (bus_if.bus_addr),
    .i_bus_wn    (bus_if.bus_wn),
    .i_bus_wdata (bus_if.bus_wdata),
    .o_spr_req   (bus_if.spr_req),
    .i_spr_gnt   (bus_if.spr_gnt),
    .o_spr_addr  (bus_if.spr_addr),
    .o_spr_wn    (bus_if.spr_wn),
    .o_spr_wdata (bus_if.spr_wdata),
    .i_spr_rdata (bus_if.spr_rdata),
    .o_dma_busy  (bus_if.dma_busy)
  );

  assign bus_if.spr_rdata = bus_if.spr_addr[7:0] ^ 8'h5A;

  int checks = 0;
  int errors = 0;

  // Independent cycle-parity reference: value seen at the next rising edge.
  logic tb_par;
  always @(posedge clk or negedge rstn)
    if (!rstn) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;

  logic [7:0]  exp_page = 8'h02;
  int gcnt = 0, req_cyc = 0, wr_cnt = 0, rd_cnt = 0, dummy = 0;
  int wr_bad = 0, rd_bad = 0, hold_bad = 0, over_bad = 0, busy_bad = 0;
  int cyc = 0, last_wr_cyc = 0, fall_cyc = 0;
  logic [15:0] last_rd_addr = 16'h0000;
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [24:0] prev_out = '0;

  always @(negedge clk) begin
    cyc++;
    if (bus_if.spr_req && !prev_req) begin
      gcnt = 0; req_cyc = 0; wr_cnt = 0; rd_cnt = 0; dummy = 0;
    end
    if (bus_if.spr_req) req_cyc++;
    if (bus_if.dma_busy !== bus_if.spr_req) busy_bad++;
    if (bus_if.spr_req && bus_if.spr_addr[15:8] == exp_page + 8'd1) over_bad++;
    if (prev_req && !prev_gnt && bus_if.spr_req &&
        {bus_if.spr_addr, bus_if.spr_wn, bus_if.spr_wdata} !== prev_out) hold_bad++;
    if (bus_if.spr_req && bus_if.spr_gnt) begin
      gcnt++;
      if (!bus_if.spr_wn) begin
        if (bus_if.spr_addr !== 16'h2004 || bus_if.spr_wdata !== (wr_cnt[7:0] ^ 8'h5A)) wr_bad++;
        wr_cnt++;
        last_wr_cyc = cyc;
      end else if (bus_if.spr_addr == 16'h2004) begin
        dummy++;
      end else begin
        if (bus_if.spr_addr !== {exp_page, rd_cnt[7:0]}) rd_bad++;
        rd_cnt++;
        last_rd_addr = bus_if.spr_addr;
      end
    end
    if (prev_req && !bus_if.spr_req) fall_cyc = cyc;
    prev_req = bus_if.spr_req;
    prev_gnt = bus_if.spr_gnt;
    prev_out = {bus_if.spr_addr, bus_if.spr_wn, bus_if.spr_wdata};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(bus_if.spr_req),   32'h0);
    chk({tag, "_addr"},  32'(bus_if.spr_addr),  32'h0);
    chk({tag, "_wn"},    32'(bus_if.spr_wn),    32'h1);
    chk({tag, "_wdata"}, 32'(bus_if.spr_wdata), 32'h0);
    chk({tag, "_busy"},  32'(bus_if.dma_busy),  32'h0);
  endtask

  task automatic trigger(input logic [7:0] pg, input logic odd);
    while (tb_par !== odd) tick();
    bus_if.bus_wn    = 1'b0;
    bus_if.bus_addr  = 16'h4014;
    bus_if.bus_wdata = pg;
    tick();
    bus_if.bus_wn    = 1'b1;
    bus_if.bus_addr  = 16'h0000;
    chk("trig_req",  32'(bus_if.spr_req),  32'h1);
    chk("trig_busy", 32'(bus_if.dma_busy), 32'h1);
  endtask

  task automatic run_xfer(input bit stall, input bit retrig, input bit rst_mid);
    int  stall_left = 0;
    bit  s1 = 0, s2 = 0, rt = 0;
    for (int c = 0; c < 1200; c++) begin
      if (!bus_if.spr_req) break;
      bus_if.spr_gnt = 1'b1;
      if (stall && !s1 && bus_if.spr_wn && bus_if.spr_addr == {exp_page, 8'h40}) begin
        s1 = 1; stall_left = 3;
      end
      if (stall && !s2 && !bus_if.spr_wn && wr_cnt == 128) begin
        s2 = 1; stall_left = 4;
      end
      if (stall_left > 0) begin
        bus_if.spr_gnt = 1'b0;
        stall_left--;
      end
      bus_if.bus_wn   = 1'b1;
      bus_if.bus_addr = 16'h0000;
      if (retrig && !rt && wr_cnt == 32) begin
        rt = 1;
        bus_if.bus_wn    = 1'b0;
        bus_if.bus_addr  = 16'h4014;
        bus_if.bus_wdata = 8'h03;
      end
      if (rst_mid && wr_cnt == 16 && bus_if.spr_wn && bus_if.spr_addr == {exp_page, 8'h10}) begin
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        return;
      end
      tick();
    end
    chk("xfer_done", 32'(bus_if.spr_req), 32'h0);
    tick();
  endtask

  initial begin
    bus_if.bus_addr  = 16'h0000;
    bus_if.bus_wn    = 1'b1;
    bus_if.bus_wdata = 8'h00;
    bus_if.spr_gnt   = 1'b0;
    #12;
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();
    tick();
    check_reset_outputs("idle");

    // Basic even-cycle copy of page 2
    exp_page = 8'h02;
    trigger(8'h02, 1'b0);
    run_xfer(0, 0, 0);
    chk("basic_gcnt",   32'(gcnt),    32'd513);
    chk("basic_reqcyc", 32'(req_cyc), 32'd513);
    chk("basic_dummy",  32'(dummy),   32'd1);
    chk("basic_wrcnt",  32'(wr_cnt),  32'd256);
    chk("basic_wrbad",  32'(wr_bad),  32'd0);
    chk("basic_rdbad",  32'(rd_bad),  32'd0);
    chk("basic_lastrd", 32'(last_rd_addr), 32'h02FF);
    chk("basic_fall",   32'(fall_cyc), 32'(last_wr_cyc + 1));

    // Odd-cycle trigger
    trigger(8'h02, 1'b1);
    run_xfer(0, 0, 0);
    chk("odd_gcnt",  32'(gcnt),   32'd514);
    chk("odd_dummy", 32'(dummy),  32'd2);
    chk("odd_wrcnt", 32'(wr_cnt), 32'd256);
    chk("odd_wrbad", 32'(wr_bad), 32'd0);

    // Grant stalls plus an ignored $4014 write mid-transfer
    trigger(8'h02, 1'b0);
    run_xfer(1, 1, 0);
    chk("stall_gcnt",   32'(gcnt),     32'd513);
    chk("stall_reqcyc", 32'(req_cyc),  32'd520);
    chk("stall_hold",   32'(hold_bad), 32'd0);
    chk("stall_wrcnt",  32'(wr_cnt),   32'd256);
    chk("stall_wrbad",  32'(wr_bad),   32'd0);
    chk("retrig_rdbad", 32'(rd_bad),   32'd0);
    chk("retrig_lastrd", 32'(last_rd_addr), 32'h02FF);

    // Page 7: must end at $07FF, never touch $08xx
    exp_page = 8'h07;
    trigger(8'h07, 1'b0);
    run_xfer(0, 0, 0);
    chk("wrap_lastrd", 32'(last_rd_addr), 32'h07FF);
    chk("wrap_over",   32'(over_bad),     32'd0);
    chk("wrap_wrcnt",  32'(wr_cnt),       32'd256);
    chk("wrap_rdbad",  32'(rd_bad),       32'd0);

    // Reset at idx 0x10, then a fresh transfer from idx 0
    exp_page = 8'h02;
    trigger(8'h02, 1'b0);
    run_xfer(0, 0, 1);
    #3;
    rstn = 1'b1;
    tick();
    tick();
    check_reset_outputs("post_rst");
    trigger(8'h02, 1'b0);
    run_xfer(0, 0, 0);
    chk("restart_gcnt",  32'(gcnt),   32'd513);
    chk("restart_wrcnt", 32'(wr_cnt), 32'd256);
    chk("restart_wrbad", 32'(wr_bad), 32'd0);
    chk("restart_rdbad", 32'(rd_bad), 32'd0);
    chk("busy_tracks_req", 32'(busy_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spr_dma_ctrl.md
# spr_dma_ctrl

Sprite (OAM) DMA initiator for the NES CPU-side bus. It snoops CPU writes to $4014 and requests the bus from the bus arbiter through the sprite port. When granted, it copies 256 bytes from page $XX00–$XXFF to the PPU OAM data register $2004 as alternating read/write cycles. It sits between the arbiter's `spr_*` port and the shared bus, and is the requester end of the arbitration handshake the arbiter serves.

## Interface
Parameters:
- `OAMDMA_ADDR`, 16'h4014: trigger register address.
- `OAMDATA_ADDR`, 16'h2004: destination register address.

Ports:
- `i_clk`  in  1  CPU clock. Single clock domain.
- `i_rstn`  in  1  Asynchronous, active-low reset.
- `i_bus_addr`  in  16  Shared bus address (snoop).
- `i_bus_wn`  in  1  Shared bus write strobe. 0 = write.
- `i_bus_wdata`  in  8  Shared bus write data (snoop).
- `o_spr_req`  out  1  Bus request to the arbiter.
- `i_spr_gnt`  in  1  Grant. High = this block owns the bus this cycle.
- `o_spr_addr`  out  16  DMA address.
- `o_spr_wn`  out  1  1 = read, 0 = write.
- `o_spr_wdata`  out  8  Write data.
- `i_spr_rdata`  in  8  Read data. Valid at the rising edge that ends a granted read cycle.
- `o_dma_busy`  out  1  High from trigger until completion (debug).

## Operation
- Trigger condition: `i_bus_wn`=0 and `i_bus_addr`=OAMDMA_ADDR, sampled at a rising edge while in IDLE.
  - On trigger, latch `i_bus_wdata` into `page`, clear `idx`, and record `odd` = current value of the free-running cycle-parity flop.
- The cycle-parity flop toggles every cycle and resets to 0.
- States:
  - IDLE: `o_spr_req`=0. On trigger, go to ALIGN with `align_cnt` = 1 + odd.
  - ALIGN: `o_spr_req`=1, dummy read of OAMDATA_ADDR. On each granted cycle, decrement `align_cnt`. At 0, go to READ.
  - READ: addr = {page, idx}, wn=1. On a granted cycle, capture `i_spr_rdata` into `data_r` and go to WRITE.
  - WRITE: addr = OAMDATA_ADDR, wn=0, wdata = `data_r`. On a granted cycle, `idx`++. If `idx` was 8'hFF, go to IDLE; otherwise go to READ.
- In any cycle with `i_spr_gnt`=0, nothing advances. State, `idx`, `data_r` and all outputs hold, and the cycle is retried when grant returns. This covers both a DMC steal and the initial wait.
- `o_spr_req` stays high continuously from ALIGN through the last WRITE, including non-granted cycles.
- A $4014 write while not in IDLE is ignored.
- Address arithmetic: `idx` is 8-bit. The source address never carries into `page`: $12FF is followed by completion, never $1300.
- Total granted cycles per transfer: 513 when `odd`=0, 514 when `odd`=1.

## Timing
- Outputs are decoded from registered state only. There is no combinational path from `i_spr_gnt` or `i_spr_rdata` to any output.
- Trigger sampled at edge E: `o_spr_req` and `o_dma_busy` are high in the cycle after E.
- Byte transfer: read at granted cycle k, write at the next granted cycle.
- Completion: `o_spr_req` and `o_dma_busy` deassert in the cycle after the granted final WRITE. A new trigger is accepted from that cycle onward.
- Reset values: `o_spr_req`=0, `o_spr_addr`=16'h0000, `o_spr_wn`=1, `o_spr_wdata`=8'h00, `o_dma_busy`=0. State = IDLE, `idx`=0, parity=0.
- Reset asserted mid-transfer: immediate return to reset values. The transfer is abandoned, with no partial completion and no resume.

## Structure
- Shared package `nes_pkg`: `OAMDMA_ADDR` and `OAMDATA_ADDR` constants, and the DMA state enum (IDLE, ALIGN, READ, WRITE).
- Single module, no sub-modules. Expected size is about 150 lines of RTL.

## Test plan
- **Basic copy:** preload $0200–$02FF with `i`^8'h5A. Write 8'h02 to $4014 on an even cycle with grant always high. Expect 513 granted cycles and 256 writes to $2004 carrying values 8'h5A, 8'h5B, …, in order. `o_spr_req` drops 1 cycle after the last write.
- **Odd alignment:** same transfer triggered on an odd cycle. Expect 2 dummy cycles and 514 total.
- **Grant stall:** drop `i_spr_gnt` for 3 cycles in READ at idx=8'h40, and again for 4 cycles in WRITE at idx=8'h80. Expect outputs held during the stalls, no skipped or duplicated bytes, and totals extended by exactly 7.
- **Page wrap:** trigger with page 8'h07. The last read address is $07FF and there is never a $0800 access.
- **Retrigger ignored:** a $4014 write with 8'h03 during a busy transfer leaves `page`=8'h02 unchanged.
- **Reset mid-op:** assert `i_rstn` low at idx=8'h10. All outputs return to reset values immediately. A new trigger after release restarts at idx 0.
